// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM with wait-stated memory handshakes,
// a retired-instruction counter and a sticky memory-timeout trap.
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 instr_ready,
  output logic                 IRwrite,
  output logic                 RegWrite,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [2:0]           ImmSrc,
  output logic                 PCen,
  output logic                 PCsrc,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  state_t        state;
  logic [6:0]    ir_op;
  logic [2:0]    ir_f3;
  logic          ir_f7;
  logic [WW-1:0] wait_cnt;

  logic is_ialu, is_r, is_lw, is_sw;
  logic is_br, is_jal, legal, taken;
  logic expired;

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_ialu = (ir_op == 7'b0010011) &&
                   (ir_f3 == 3'b000 || ir_f3 == 3'b110 ||
                    ir_f3 == 3'b111);
  assign is_r    = (ir_op == 7'b0110011) && (ir_f3 == 3'b000);
  assign is_lw   = (ir_op == 7'b0000011) && (ir_f3 == 3'b010);
  assign is_sw   = (ir_op == 7'b0100011) && (ir_f3 == 3'b010);
  assign is_br   = (ir_op == 7'b1100011) && (ir_f3[2:1] == 2'b00);
  assign is_jal  = (ir_op == 7'b1101111);
  assign legal   = is_ialu | is_r | is_lw | is_sw | is_br | is_jal;
  // funct3[0] distinguishes bne from beq
  assign taken   = is_br && (ir_f3[0] ? !EQ : EQ);
  assign expired = (wait_cnt == WW'(TIMEOUT - 1));

  always_comb begin
    instr_ready = (state == FETCH);
    trap        = (state == TRAP);
    IRwrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUctrl     = 3'd0;
    ALUsrc      = 1'b0;
    ImmSrc      = 3'd0;
    PCen        = 1'b0;
    PCsrc       = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ResultSrc   = 2'd0;
    // ALU controls stay stable from EXEC through MEM/WB
    if (state == EXEC || state == MEM || state == WB) begin
      unique case (1'b1)
        is_ialu: begin
          ALUsrc  = 1'b1;
          ALUctrl = (ir_f3 == 3'b110) ? 3'd3 :
                    (ir_f3 == 3'b111) ? 3'd2 : 3'd0;
        end
        is_r:   ALUctrl = ir_f7 ? 3'd1 : 3'd0;
        is_lw:  ALUsrc  = 1'b1;
        is_sw: begin
          ALUsrc = 1'b1;
          ImmSrc = 3'd2;
        end
        is_br: begin
          ALUctrl = 3'd1;
          ImmSrc  = 3'd1;
        end
        is_jal: ImmSrc = 3'd3;
        default: ;
      endcase
    end
    case (state)
      FETCH: begin
        IRwrite = instr_valid;
        PCen    = instr_valid;
      end
      EXEC: begin
        PCen  = is_jal | taken;
        PCsrc = is_jal | taken;
      end
      MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_lw ? 2'd1 : is_jal ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      ir_op    <= '0;
      ir_f3    <= '0;
      ir_f7    <= 1'b0;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            state <= DECODE;
            ir_op <= instr[6:0];
            ir_f3 <= instr[14:12];
            ir_f7 <= instr[30];
          end else if (expired) begin
            state <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DECODE: state <= legal ? EXEC : TRAP;
        EXEC: begin
          if (is_br) begin
            state   <= FETCH;
            instret <= instret + CNT_WIDTH'(1);
          end else if (is_lw || is_sw) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          // completion takes priority over an expiring wait
          if (mem_ready) begin
            if (is_lw) begin
              state <= WB;
            end else begin
              state   <= FETCH;
              instret <= instret + CNT_WIDTH'(1);
            end
          end else if (expired) begin
            state <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        WB: begin
          state   <= FETCH;
          instret <= instret + CNT_WIDTH'(1);
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected
// traces built from the instruction semantics, driven with random waits.
module tb_multicycle_control_unit;

  localparam int TMO = 4;
  localparam int TRAP_HOLD = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;
  logic        instr_ready, IRwrite, RegWrite, ALUsrc;
  logic [2:0]  ALUctrl, ImmSrc;
  logic        PCen, PCsrc, MemRead, MemWrite, trap;
  logic [1:0]  ResultSrc;
  logic [31:0] instret;

  multicycle_control_unit #(.CNT_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .EQ(EQ), .mem_ready(mem_ready),
    .instr_ready(instr_ready), .IRwrite(IRwrite),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .ImmSrc(ImmSrc), .PCen(PCen), .PCsrc(PCsrc),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_rdy;
    logic       irw;
    logic       rw;
    logic [2:0] aluc;
    logic       asrc;
    logic [2:0] imm;
    logic       pcen;
    logic       pcsrc;
    logic       mrd;
    logic       mwr;
    logic [1:0] res;
    logic       trp;
  } ctl_t;

  typedef struct {
    logic        iv;
    logic        mr;
    logic        eq;
    logic [31:0] data;
    ctl_t        exp;
    bit          care;
  } entry_t;

  ctl_t   obs;
  entry_t q[$];
  int     checks = 0;
  int     failures = 0;
  int     model_cnt = 0;

  assign obs = {instr_ready, IRwrite, RegWrite, ALUctrl, ALUsrc,
                ImmSrc, PCen, PCsrc, MemRead, MemWrite, ResultSrc,
                trap};

  function automatic ctl_t strip(ctl_t c);
    c.aluc = '0;
    c.asrc = 1'b0;
    c.imm  = '0;
    return c;
  endfunction

  task automatic push(logic iv, logic mr, logic eq,
                      logic [31:0] d, ctl_t e, bit care);
    entry_t x;
    x.iv = iv; x.mr = mr; x.eq = eq;
    x.data = d; x.exp = e; x.care = care;
    q.push_back(x);
  endtask

  task automatic push_trap();
    ctl_t e;
    for (int i = 0; i < TRAP_HOLD; i++) begin
      e = '0;
      e.trp = 1'b1;
      push(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e, 1);
    end
  endtask

  // Reference: expected per-cycle outputs and inputs for one instruction.
  task automatic build(logic [31:0] w, logic eq, int fd, int md);
    ctl_t e;
    logic [6:0] op;
    logic [2:0] f3;
    bit ialu, r, lw, sw, br, jal, tk;
    logic [2:0] ac, im;
    logic as;
    op = w[6:0];
    f3 = w[14:12];
    ialu = (op == 7'h13) && (f3 == 0 || f3 == 6 || f3 == 7);
    r    = (op == 7'h33) && (f3 == 0);
    lw   = (op == 7'h03) && (f3 == 2);
    sw   = (op == 7'h23) && (f3 == 2);
    br   = (op == 7'h63) && (f3 == 0 || f3 == 1);
    jal  = (op == 7'h6F);
    tk   = br && ((f3 == 0) ? eq : !eq);
    q.delete();
    for (int i = 0; i < fd && i < TMO; i++) begin
      e = '0;
      e.ir_rdy = 1'b1;
      push(1'b0, 1'($urandom), 1'($urandom), $urandom, e, 1);
    end
    if (fd >= TMO) begin
      push_trap();
      return;
    end
    e = '0;
    e.ir_rdy = 1'b1; e.irw = 1'b1; e.pcen = 1'b1;
    push(1'b1, 1'($urandom), 1'($urandom), w, e, 1);
    e = '0;
    push(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e, 1);
    if (!(ialu || r || lw || sw || br || jal)) begin
      push_trap();
      return;
    end
    ac = 0; im = 0; as = 0;
    if (ialu) begin
      as = 1;
      ac = (f3 == 0) ? 3'd0 : (f3 == 6) ? 3'd3 : 3'd2;
    end
    if (r) ac = w[30] ? 3'd1 : 3'd0;
    if (lw) as = 1;
    if (sw) begin as = 1; im = 2; end
    if (br) begin ac = 1; im = 1; end
    if (jal) im = 3;
    e = '0;
    e.aluc = ac; e.asrc = as; e.imm = im;
    e.pcen = jal || tk; e.pcsrc = jal || tk;
    push(1'($urandom), 1'($urandom), eq, $urandom, e, 1);
    if (br) begin
      model_cnt++;
      return;
    end
    if (lw || sw) begin
      e = '0;
      e.mrd = lw; e.mwr = sw;
      for (int i = 0; i < md && i < TMO; i++)
        push(1'($urandom), 1'b0, 1'($urandom), $urandom, e, 0);
      if (md >= TMO) begin
        push_trap();
        return;
      end
      push(1'($urandom), 1'b1, 1'($urandom), $urandom, e, 0);
      if (sw) begin
        model_cnt++;
        return;
      end
    end
    e = '0;
    e.rw = 1'b1;
    e.res = lw ? 2'd1 : jal ? 2'd2 : 2'd0;
    if (ialu || r) begin
      e.aluc = ac; e.asrc = as; e.imm = im;
    end
    push(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e,
         ialu || r);
    model_cnt++;
  endtask

  task automatic run_trace(string tag, int limit);
    ctl_t a, x;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clk);
      instr_valid = q[i].iv;
      mem_ready   = q[i].mr;
      EQ          = q[i].eq;
      instr       = q[i].data;
      #1;
      a = q[i].care ? obs : strip(obs);
      x = q[i].care ? q[i].exp : strip(q[i].exp);
      checks++;
      if (a !== x) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs got %h expected %h",
                 tag, i, a, x);
      end
    end
  endtask

  task automatic check_count(string tag);
    @(posedge clk);
    #1;
    checks++;
    if (instret !== 32'(model_cnt)) begin
      failures++;
      $display("FAIL %s instret: got %0d expected %0d",
               tag, instret, model_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  function automatic logic [31:0] make_instr(int cls);
    logic [31:0] w;
    logic [2:0] f3;
    w = $urandom;
    f3 = 3'd0;
    case (cls)
      0: begin
        w[6:0] = 7'h13;
        f3 = ($urandom_range(0, 2) == 0) ? 3'd0 :
             ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
      end
      1: begin
        w[6:0] = 7'h33;
        w[31:25] = w[30] ? 7'b0100000 : 7'b0000000;
      end
      2: begin w[6:0] = 7'h03; f3 = 3'd2; end
      3: begin w[6:0] = 7'h23; f3 = 3'd2; end
      4: begin w[6:0] = 7'h63; f3 = {2'b00, 1'($urandom)}; end
      default: w[6:0] = 7'h6F;
    endcase
    if (cls != 5) w[14:12] = f3;
    return w;
  endfunction

  task automatic test_reset();
    ctl_t e;
    e = '0;
    e.ir_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== e || instret !== 0) begin
      failures++;
      $display("FAIL reset_async: outputs %h cnt %0d expected %h cnt 0",
               obs, instret, e);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== e || instret !== 0) begin
      failures++;
      $display("FAIL reset_release: outputs %h cnt %0d expected %h",
               obs, instret, e);
    end
  endtask

  task automatic test_addi();
    build(32'h00500093, 1'b0, 0, 0);
    checks++;
    if (q.size() != 4) begin
      failures++;
      $display("FAIL addi_len: got %0d expected 4", q.size());
    end
    run_trace("addi", 99);
    check_count("addi");
  endtask

  task automatic test_sub();
    build(32'h402081B3, 1'b1, 1, 0);
    run_trace("sub", 99);
    check_count("sub");
  endtask

  task automatic test_lw_wait();
    build(32'h00802283, 1'b0, 0, 3);
    checks++;
    if (q.size() != 8) begin
      failures++;
      $display("FAIL lw_len: got %0d expected 8", q.size());
    end
    run_trace("lw_wait", 99);
    check_count("lw_wait");
  endtask

  task automatic test_bne();
    build(32'h00209463, 1'b0, 0, 0);
    run_trace("bne_taken", 99);
    check_count("bne_taken");
    build(32'h00209463, 1'b1, 0, 0);
    run_trace("bne_not_taken", 99);
    check_count("bne_not_taken");
    build(32'h00208463, 1'b1, 2, 0);
    run_trace("beq_taken", 99);
    check_count("beq_taken");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      build(make_instr($urandom_range(0, 5)), 1'($urandom),
            $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      run_trace("random", 99);
      check_count("random");
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3];
    bad[0] = 32'h0000007F;
    bad[1] = 32'h00109093;
    bad[2] = 32'h00000003;
    for (int n = 0; n < 3; n++) begin
      build(bad[n], 1'b0, 0, 0);
      run_trace("illegal", 99);
      check_count("illegal_frozen");
      do_reset();
    end
  endtask

  task automatic test_timeouts();
    build(make_instr(0), 1'b0, 1, 0);
    run_trace("pre_timeout", 99);
    check_count("pre_timeout");
    build(make_instr(3), 1'b0, 0, TMO);
    run_trace("mem_timeout", 99);
    check_count("mem_timeout_frozen");
    do_reset();
    build(make_instr(0), 1'b0, TMO, 0);
    run_trace("fetch_timeout", 99);
    check_count("fetch_timeout_frozen");
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    build(32'h00802283, 1'b0, 0, 3);
    run_trace("lw_abort", 5);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (MemRead !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_async: MemRead %b ready %b expected 0 1",
               MemRead, instr_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = 0;
    #1;
    checks++;
    if (instret !== 0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_release: cnt %0d ready %b expected 0 1",
               instret, instr_ready);
    end
    build(make_instr(5), 1'b0, 0, 0);
    run_trace("after_abort", 99);
    check_count("after_abort");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_lw_wait();
    test_bne();
    test_random();
    test_illegal();
    test_timeouts();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
